// File: rtl/data_mem_pkg.sv
// Shared types and default sizing for the data memory controller.
package data_mem_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int ADDR_W_DEF     = 32;
  localparam int DEPTH_LOG2_DEF = 16;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

endpackage

// File: rtl/data_mem_ram.sv
// Single-port word storage with byte-enable writes and a registered
// read-before-write output port.
module data_mem_ram #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 16
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic [DATA_W/8-1:0]     be,
  input  logic [DEPTH_LOG2-1:0]   addr,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DATA_W-1:0]       rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  // NOTE: storage and its read register take no reset so they map onto RAM
  // macros; the controller masks rdata whenever it is not meaningful.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int i = 0; i < DATA_W/8; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Request/response front end for data_mem_ram. Defining DATA_MEM_CTRL_CLEAR_EN
// makes reset sweep the whole storage to zero before requests are accepted.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

`ifdef DATA_MEM_CTRL_CLEAR_EN
  localparam state_t RST_STATE = CLEAR;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  state_t                  state, state_nxt;
  logic [DEPTH_LOG2-1:0]   clr_cnt;
  logic                    in_range;
  logic                    accept;
  logic                    rsp_is_read;

  logic                    ram_en;
  logic [DATA_W/8-1:0]     ram_be;
  logic [DEPTH_LOG2-1:0]   ram_addr;
  logic [DATA_W-1:0]       ram_wdata;
  logic [DATA_W-1:0]       ram_rdata;

  assign in_range = (req_addr >> DEPTH_LOG2) == '0;
  assign accept   = req_valid && req_ready;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= RST_STATE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)              clr_cnt <= '0;
    else if (state == CLEAR) clr_cnt <= clr_cnt + DEPTH_LOG2'(1);
  end

  // NOTE: next-state logic starts from a default so no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (state == CLEAR && clr_cnt == '1) state_nxt = IDLE;
  end

  // The RAM port is owned by the clear sweep in CLEAR and by requests in IDLE.
  always_comb begin
    req_ready = rst_n && (state == IDLE) && (!rsp_valid || rsp_ready);
    ram_en    = 1'b0;
    ram_be    = '0;
    ram_addr  = req_addr[DEPTH_LOG2-1:0];
    ram_wdata = req_wdata;
    if (state == CLEAR) begin
      ram_en    = rst_n;
      ram_be    = '1;
      ram_addr  = clr_cnt;
      ram_wdata = '0;
    end else begin
      ram_en = accept && in_range;
      ram_be = req_we ? req_be : '0;
    end
  end

  // Read data lives in the RAM output register, which only moves on a new
  // accept, so it stays stable while a response is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_is_read <= 1'b0;
    end else if (accept) begin
      rsp_valid   <= 1'b1;
      rsp_err     <= !in_range;
      rsp_is_read <= !req_we && in_range;
    end else if (rsp_ready) begin
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_is_read <= 1'b0;
    end
  end

  assign rsp_rdata = rsp_is_read ? ram_rdata : '0;

  data_mem_ram #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized and directed bench for data_mem_ctrl against a transaction-level
// memory model with an expected-response queue.
module tb_data_mem_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int BE_W   = DATA_W / 8;
`ifdef DATA_MEM_CTRL_CLEAR_EN
  localparam int DL     = 8;
  localparam bit CLR_EN = 1'b1;
`else
  localparam int DL     = 16;
  localparam bit CLR_EN = 1'b0;
`endif
  localparam int DEPTH  = 2**DL;

  typedef struct {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } rsp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;

  logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
  rsp_t              exp_q[$];
  int                clear_left = 0;
  int                n_cmp = 0;
  int                n_bad = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH_LOG2(DL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  // One clock cycle: drive, check against the model, advance to next negedge.
  task automatic step(input logic v, input logic we, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be,
                      input logic rr, output logic acc);
    logic exp_ready;
    rsp_t r;
    logic [DATA_W-1:0] w;
    req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    rsp_ready = rr;
    #1;
    exp_ready = (clear_left == 0) && (exp_q.size() == 0 || rr);
    check("req_ready", req_ready, exp_ready);
    check("rsp_valid", rsp_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("rsp_rdata", rsp_rdata, exp_q[0].rdata);
      check("rsp_err", rsp_err, exp_q[0].err);
      if (rr) void'(exp_q.pop_front());
    end
    acc = v && exp_ready;
    if (acc) begin
      r.err   = (a >> DL) != 0;
      r.rdata = '0;
      if (!r.err) begin
        w = ref_read(a);
        if (!we) r.rdata = w;
        else begin
          for (int i = 0; i < BE_W; i++) if (be[i]) w[i*8 +: 8] = d[i*8 +: 8];
          ref_mem[a] = w;
        end
      end
      exp_q.push_back(r);
    end
    @(posedge clk);
    if (clear_left > 0) clear_left--;
    @(negedge clk);
  endtask

  task automatic send(input logic we, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    logic acc;
    int   n = 0;
    do begin
      step(1'b1, we, a, d, be, 1'b1, acc);
      n++;
    end while (!acc && n < DEPTH + 20);
    check("accept_timeout", acc, 1'b1);
  endtask

  task automatic idle(input int cycles);
    logic acc;
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, '0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_req_ready", req_ready, 1'b0);
    rst_n = 1'b1;
    exp_q.delete();
    if (CLR_EN) begin
      ref_mem.delete();
      clear_left = DEPTH;
    end
  endtask

  initial begin
    logic acc;
    logic [ADDR_W-1:0] a;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Give every address the random traffic touches a known value.
    for (int i = 0; i < 32; i++) send(1'b1, ADDR_W'(i), $urandom, '1);

    // Full write, read back, then a single-byte merge.
    send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    send(1'b0, 32'h10, '0, '0);
    send(1'b1, 32'h10, 32'h000000AA, 4'h1);
    send(1'b0, 32'h10, '0, '0);
    send(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0);
    send(1'b0, 32'h10, '0, '0);

    // Out-of-range read and write leave storage alone.
    send(1'b0, 32'h0001_0000, '0, '0);
    send(1'b1, 32'h8000_0000, 32'h12345678, 4'hF);
    send(1'b0, 32'h0, '0, '0);
    idle(1);

    // Stall a read response for three cycles, then release with a new request.
    step(1'b1, 1'b0, 32'h10, '0, '0, 1'b1, acc);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'h11, 32'hCAFE0001, 4'hF, 1'b0, acc);
    step(1'b1, 1'b1, 32'h11, 32'hCAFE0001, 4'hF, 1'b1, acc);
    check("stall_release_accept", acc, 1'b1);
    idle(1);

    // Eight writes then eight reads, back to back.
    for (int i = 0; i < 8; i++) send(1'b1, ADDR_W'(i + 8), $urandom, '1);
    for (int i = 0; i < 8; i++) send(1'b0, ADDR_W'(i + 8), '0, '0);
    idle(1);

    // Reset while a response is stalled; storage is then read back.
    step(1'b1, 1'b1, 32'h3, 32'h5, 4'hF, 1'b1, acc);
    step(1'b1, 1'b0, 32'h3, '0, '0, 1'b0, acc);
    do_reset();
    send(1'b0, 32'h3, '0, '0);
    send(1'b0, 32'h10, '0, '0);
    idle(1);
    if (CLR_EN) for (int i = 0; i < 32; i++) send(1'b1, ADDR_W'(i), $urandom, '1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(9) < 8) a = ADDR_W'($urandom_range(31));
      else begin
        a = $urandom;
        a[DL] = 1'b1;
      end
      step($urandom_range(3) != 0, $urandom_range(1) == 1, a, $urandom,
           BE_W'($urandom), $urandom_range(3) != 0, acc);
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
